// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared MDU operation codes, FSM states and op-class helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [3:0] c_op_none  = 4'd0;
    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
    localparam logic [3:0] c_op_madd  = 4'd7;
    localparam logic [3:0] c_op_maddu = 4'd8;
    localparam logic [3:0] c_op_msub  = 4'd9;
    localparam logic [3:0] c_op_msubu = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op inside {c_op_mult, c_op_multu, c_op_madd, c_op_maddu,
                          c_op_msub, c_op_msubu};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {c_op_div, c_op_divu};
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {c_op_mult, c_op_madd, c_op_msub, c_op_div};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_divider.sv
// ============================================================================
// Module      : mdu_divider
// Description : Iterative unsigned restoring divider, one quotient bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             valid
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic               r_run;
    logic               r_valid;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH:0]     w_trial;

    // Borrow out of the trial subtraction lands in the top bit.
    assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
        end else if (abort) begin
            r_run   <= 1'b0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_run   <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_quo   <= dividend;
            r_rem   <= '0;
            r_div   <= divisor;
        end else if (r_run) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            if (r_cnt == c_last) begin
                r_run   <= 1'b0;
                r_valid <= 1'b1;
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign quo   = r_quo;
    assign rem   = r_rem;
    assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module      : mdu_iter
// Description : Multi-cycle multiply/MAC/divide unit owning the HI/LO pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       MDOp,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int c_cnt_max = (MULT_CYCLES > WIDTH + 1) ? MULT_CYCLES : WIDTH + 1;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH);

    mdu_state_t           r_state;
    mdu_state_t           w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_launch_mul;
    logic                 w_launch_div;
    logic                 w_write_hi;
    logic                 w_write_lo;
    logic                 w_commit_mul;
    logic                 w_commit_div;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [2*WIDTH-1:0]   w_ext1;
    logic [2*WIDTH-1:0]   w_ext2;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_hilo_next;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_div_valid;
    logic                 w_div_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_accept     = Start && (r_state == ST_IDLE) && !Flush;
    assign w_launch_mul = w_accept && is_mul_op(MDOp);
    assign w_launch_div = w_accept && is_div_op(MDOp);
    assign w_write_hi   = w_accept && (MDOp == c_op_mthi);
    assign w_write_lo   = w_accept && (MDOp == c_op_mtlo);

    // Sign-extending through the 2W-bit unsigned product yields the signed
    // product modulo 2^(2W), so one multiplier serves both flavours.
    assign w_neg1 = is_signed_op(MDOp) && Data1[WIDTH-1];
    assign w_neg2 = is_signed_op(MDOp) && Data2[WIDTH-1];
    assign w_ext1 = {{WIDTH{w_neg1}}, Data1};
    assign w_ext2 = {{WIDTH{w_neg2}}, Data2};
    assign w_prod = w_ext1 * w_ext2;
    assign w_mag1 = w_neg1 ? (~Data1 + 1'b1) : Data1;
    assign w_mag2 = w_neg2 ? (~Data2 + 1'b1) : Data2;

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk      (Clk),
        .rst      (Reset),
        .load     (w_launch_div),
        .abort    (Flush),
        .dividend (w_mag1),
        .divisor  (w_mag2),
        .quo      (w_quo),
        .rem      (w_rem),
        .valid    (w_div_valid)
    );

    // Divide-by-zero bypasses sign correction so HI returns the raw dividend.
    assign w_div_signed = (r_op == c_op_div);
    assign w_a_neg      = w_div_signed && r_a[WIDTH-1];
    assign w_b_neg      = w_div_signed && r_b[WIDTH-1];
    assign w_b_zero     = (r_b == '0);
    assign w_quo_fix    = w_b_zero ? '1 :
                          ((w_a_neg ^ w_b_neg) ? (~w_quo + 1'b1) : w_quo);
    assign w_rem_fix    = w_b_zero ? r_a : (w_a_neg ? (~w_rem + 1'b1) : w_rem);

    always_comb begin
        w_hilo_next = r_prod;
        case (r_op)
            c_op_madd, c_op_maddu: w_hilo_next = {r_hi, r_lo} + r_prod;
            c_op_msub, c_op_msubu: w_hilo_next = {r_hi, r_lo} - r_prod;
            default:               w_hilo_next = r_prod;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_commit_mul = 1'b0;
        w_commit_div = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch_mul) begin
                    w_state_next = ST_MUL;
                end else if (w_launch_div) begin
                    w_state_next = ST_DIV;
                end
            end
            ST_MUL: begin
                if (Flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_mul_last) begin
                    w_state_next = ST_IDLE;
                    w_commit_mul = 1'b1;
                end
            end
            ST_DIV: begin
                if (Flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_div_last) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_next = ST_IDLE;
                w_commit_div = !Flush && w_div_valid;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_op   <= c_op_none;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= w_commit_mul | w_commit_div;

            if (w_launch_mul || w_launch_div) begin
                r_op   <= MDOp;
                r_a    <= Data1;
                r_b    <= Data2;
                r_prod <= w_prod;
                r_cnt  <= c_cnt_w'(1);
            end else if (w_state_next == ST_IDLE) begin
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end

            if (w_commit_mul) begin
                {r_hi, r_lo} <= w_hilo_next;
            end else if (w_commit_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                if (w_write_hi) r_hi <= Data1;
                if (w_write_lo) r_lo <= Data1;
            end
        end
    end

    assign Busy = (r_state != ST_IDLE);
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

`default_nettype wire
